// File: rtl/spw_babasu_status_pio_in.sv
// spw_babasu_status_pio_in
// Avalon-MM slave input port for SpaceWire link status lines. The lines are
// synchronised into clk, optionally debounced, edge-detected into a sticky
// write-1-to-clear capture register, and combined with a mask into a level irq.
// Optional feature macro: SPW_STATUS_DEBOUNCE_EN adds a per-bit stability
// filter of DEBOUNCE_CYCLES cycles between the synchroniser and the edge logic.
//
// Bus handshake: there is no wait state. A write is taken on the rising clk
// edge whenever chipselect is high and write_n is low. A read is pure
// combinational decode of address, so readdata is valid in the same cycle.
//
// Register map: 0 DATA (RO), 1 reserved (reads 0), 2 IRQMASK (RW), 3 EDGECAP (W1C).
module spw_babasu_status_pio_in #(
  parameter int              WIDTH           = 8,
  parameter int              EDGE_TYPE       = 0,
  parameter logic [WIDTH-1:0] RESET_MASK     = '0,
  parameter int              DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] f_d;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] clr;
  logic [1:0]       warm_cnt;
  logic             cap_en;
  logic             wr_en;
  logic             unused_bits;

  // Upper writedata bits are deliberately ignored.
  assign unused_bits = (^writedata) ^ (DEBOUNCE_CYCLES == 0);

  // Two-flop synchroniser for the asynchronous status lines.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
    end
  end

`ifdef SPW_STATUS_DEBOUNCE_EN
  logic [7:0] db_cnt [WIDTH];

  // Per-bit stability filter: f follows s2 only after it has differed for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f <= '0;
      for (int i = 0; i < WIDTH; i++) db_cnt[i] <= 8'd0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] == f[i]) begin
          db_cnt[i] <= 8'd0;
        end else if (db_cnt[i] == 8'(DEBOUNCE_CYCLES - 1)) begin
          f[i]      <= s2[i];
          db_cnt[i] <= 8'd0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 8'd1;
        end
      end
    end
  end
`else
  assign f = s2;
`endif

  // Delayed copy of the filtered value plus the warm-up counter that masks start-up edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f_d      <= '0;
      warm_cnt <= 2'd0;
    end else begin
      f_d <= f;
      if (warm_cnt != 2'd3) warm_cnt <= warm_cnt + 2'd1;
    end
  end

  assign cap_en = (warm_cnt == 2'd3);
  assign wr_en  = chipselect & ~write_n;

  // Edge selection is fixed at elaboration by EDGE_TYPE.
  always_comb begin
    edge_det = f & ~f_d;
    case (EDGE_TYPE)
      1:       edge_det = ~f & f_d;
      2:       edge_det = f ^ f_d;
      default: edge_det = f & ~f_d;
    endcase
  end

  // Clear vector for the capture register; only an addr-3 write produces one.
  always_comb begin
    clr = '0;
    if (wr_en && address == 2'd3) clr = writedata[WIDTH-1:0];
  end

  // Mask register and sticky capture flags; a new edge beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask <= RESET_MASK;
      edgecap <= '0;
    end else begin
      if (wr_en && address == 2'd2) irqmask <= writedata[WIDTH-1:0];
      edgecap <= (edgecap & ~clr) | (edge_det & {WIDTH{cap_en}});
    end
  end

  // Zero-latency read decode; unused upper bits read as zero.
  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = f;
      2'd2:    readdata[WIDTH-1:0] = irqmask;
      2'd3:    readdata[WIDTH-1:0] = edgecap;
      default: readdata = '0;
    endcase
  end

  assign irq = |(edgecap & irqmask);

endmodule
